// File: rtl/fifo_rsp_wc_pkg.sv
// Shared defaults and helpers for the response FIFO with upsizing width conversion.
package fifo_rsp_pkg;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_IN_WIDTH   = 32;
  localparam int DEF_OUT_WIDTH  = 128;

  // One extra pointer bit separates the full and empty states when the low bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_rsp_wc_if.sv
// BIU-side beat channel and processor-side word channel of the response FIFO.
interface fifo_rsp_wc_if
  import fifo_rsp_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
);
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W = ptr_w(FIFO_DEPTH);

  logic                 biu_rsp_valid;
  logic                 biu_rsp_ready;
  logic [IN_WIDTH-1:0]  biu_rsp_rdata;
  logic                 biu_rsp_last;
  logic                 fifo_rsp_valid;
  logic                 fifo_rsp_ready;
  logic [OUT_WIDTH-1:0] fifo_rsp_rdata;
  logic [RATIO-1:0]     fifo_rsp_mask;
  logic                 fifo_rsp_last;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_afull;

  modport master (
    output biu_rsp_valid, biu_rsp_rdata, biu_rsp_last, fifo_rsp_ready,
    input  biu_rsp_ready, fifo_rsp_valid, fifo_rsp_rdata, fifo_rsp_mask,
    input  fifo_rsp_last, fifo_count, fifo_afull
  );

  modport slave (
    input  biu_rsp_valid, biu_rsp_rdata, biu_rsp_last, fifo_rsp_ready,
    output biu_rsp_ready, fifo_rsp_valid, fifo_rsp_rdata, fifo_rsp_mask,
    output fifo_rsp_last, fifo_count, fifo_afull
  );

endinterface

// File: rtl/fifo_rsp_wc_packer.sv
// Packs narrow BIU beats into one wide word; closes early on the last beat of a response.
module rsp_packer
  import fifo_rsp_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        beat_vld,
  input  logic [IN_WIDTH-1:0]         beat_data,
  input  logic                        beat_last,
  output logic                        push_vld,
  output logic [OUT_WIDTH-1:0]        push_data,
  output logic [OUT_WIDTH/IN_WIDTH-1:0] push_mask,
  output logic                        push_last
);
  localparam int RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [LANE_W-1:0]    lane_p0;
  logic [OUT_WIDTH-1:0] acc_p0;
  logic [RATIO-1:0]     mask_p0;
  logic [OUT_WIDTH-1:0] merged_data;
  logic [RATIO-1:0]     merged_mask;
  logic                 close;
  int                   shamt;

  // Unwritten lanes stay zero because the accumulator is cleared on every close.
  always_comb begin
    shamt       = int'(lane_p0) * IN_WIDTH;
    merged_data = acc_p0 | (OUT_WIDTH'(beat_data) << shamt);
    merged_mask = mask_p0 | (RATIO'(1) << lane_p0);
  end

  assign close     = (lane_p0 == LAST_LANE) || beat_last;
  assign push_vld  = beat_vld && close;
  assign push_data = merged_data;
  assign push_mask = merged_mask;
  assign push_last = beat_last;

  // p0: lane counter, accumulator and mask of the word being assembled
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_p0 <= '0;
      acc_p0  <= '0;
      mask_p0 <= '0;
    end else if (beat_vld) begin
      if (close) begin
        lane_p0 <= '0;
        acc_p0  <= '0;
        mask_p0 <= '0;
      end else begin
        lane_p0 <= lane_p0 + LANE_W'(1);
        acc_p0  <= merged_data;
        mask_p0 <= merged_mask;
      end
    end
  end

endmodule

// File: rtl/fifo_rsp_wc.sv
// Response FIFO: packs BIU beats into wide words and presents them first-word-fall-through.
module fifo_rsp_wc
  import fifo_rsp_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int AFULL_THRESH = FIFO_DEPTH - 2
)(
  input  logic          clk,
  input  logic          rst,
  fifo_rsp_wc_if.slave  bus
);
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int PTR_W = ptr_w(FIFO_DEPTH);
  localparam int AW    = PTR_W - 1;

  if (OUT_WIDTH % IN_WIDTH != 0) begin : g_bad_ratio
    $error("fifo_rsp_wc: OUT_WIDTH must be an integer multiple of IN_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_rsp_wc: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > FIFO_DEPTH)) begin : g_bad_afull
    $error("fifo_rsp_wc: AFULL_THRESH must lie in 1..FIFO_DEPTH");
  end

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic [RATIO-1:0]     mask;
    logic                 last;
  } entry_t;

  entry_t               mem [FIFO_DEPTH];
  entry_t               head;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic                 biu_ready;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [OUT_WIDTH-1:0] pk_data;
  logic [RATIO-1:0]     pk_mask;
  logic                 pk_last;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // Ready ignores whether the beat would close a word, so the packer never runs ahead of storage.
  assign biu_ready = !full && !rst;
  assign accept    = bus.biu_rsp_valid && biu_ready;
  assign pop       = !empty && bus.fifo_rsp_ready;

  rsp_packer #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .beat_vld  (accept),
    .beat_data (bus.biu_rsp_rdata),
    .beat_last (bus.biu_rsp_last),
    .push_vld  (push),
    .push_data (pk_data),
    .push_mask (pk_mask),
    .push_last (pk_last)
  );

  // p0: read/write pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // p0: word storage, written once per closed word
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{data: pk_data, mask: pk_mask, last: pk_last};
  end

  assign head = mem[rd_ptr[AW-1:0]];

  // Head fields are forced to zero while empty, so storage needs no reset of its own.
  assign bus.fifo_rsp_valid = !empty;
  assign bus.fifo_rsp_rdata = empty ? '0   : head.data;
  assign bus.fifo_rsp_mask  = empty ? '0   : head.mask;
  assign bus.fifo_rsp_last  = empty ? 1'b0 : head.last;
  assign bus.biu_rsp_ready  = biu_ready;
  assign bus.fifo_count     = count;
  assign bus.fifo_afull     = (count >= PTR_W'(AFULL_THRESH));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_count_bounded:     assert property (@(posedge clk) disable iff (rst) count <= PTR_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_fifo_rsp_wc.sv
// Scoreboard bench for fifo_rsp_wc: 32->128 packing instance plus a 64->64 pass-through instance.
module tb_fifo_rsp_wc;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fifo_rsp_wc_if #(.FIFO_DEPTH(DEPTH), .IN_WIDTH(32), .OUT_WIDTH(128)) b0 ();
  fifo_rsp_wc_if #(.FIFO_DEPTH(DEPTH), .IN_WIDTH(64), .OUT_WIDTH(64))  b1 ();

  fifo_rsp_wc #(.FIFO_DEPTH(DEPTH), .IN_WIDTH(32), .OUT_WIDTH(128), .AFULL_THRESH(2)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  fifo_rsp_wc #(.FIFO_DEPTH(DEPTH), .IN_WIDTH(64), .OUT_WIDTH(64), .AFULL_THRESH(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  typedef struct { logic [127:0] data; logic [3:0] mask; logic last; } w0_t;
  typedef struct { logic [63:0] data; logic last; } w1_t;

  w0_t q0[$];
  w1_t q1[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp0(input logic [127:0] d, input logic [3:0] m, input logic l);
    w0_t e;
    e.data = d; e.mask = m; e.last = l;
    q0.push_back(e);
  endtask

  task automatic send0(input logic [31:0] d, input logic l);
    logic took;
    int   n;
    took = 1'b0;
    n    = 0;
    b0.biu_rsp_valid = 1'b1;
    b0.biu_rsp_rdata = d;
    b0.biu_rsp_last  = l;
    while (!took && n < 100) begin
      @(negedge clk);
      took = b0.biu_rsp_ready;
      step();
      n++;
    end
    b0.biu_rsp_valid = 1'b0;
    b0.biu_rsp_last  = 1'b0;
    total++;
    if (!took) begin
      bad++;
      $display("FAIL send0_accept data=%h got ready=0 need ready=1 within 100 cycles", d);
    end
  endtask

  task automatic pop0(output logic [127:0] d, output logic [3:0] m, output logic l, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    d  = '0;
    m  = '0;
    l  = 1'b0;
    b0.fifo_rsp_ready = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (b0.fifo_rsp_valid) begin
        ok = 1'b1;
        d  = b0.fifo_rsp_rdata;
        m  = b0.fifo_rsp_mask;
        l  = b0.fifo_rsp_last;
      end
      step();
      n++;
    end
    b0.fifo_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    total++;
    if ({b0.biu_rsp_ready, b1.biu_rsp_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready_low got=%b need=00", {b0.biu_rsp_ready, b1.biu_rsp_ready});
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({b0.biu_rsp_ready, b0.fifo_rsp_valid, b0.fifo_count, b0.fifo_afull, b0.fifo_rsp_mask, b0.fifo_rsp_last}
        !== {1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_status got rdy=%b vld=%b cnt=%0d afull=%b mask=%b last=%b need rdy=1 vld=0 cnt=0 afull=0 mask=0000 last=0",
               b0.biu_rsp_ready, b0.fifo_rsp_valid, b0.fifo_count, b0.fifo_afull, b0.fifo_rsp_mask, b0.fifo_rsp_last);
    end
    total++;
    if (b0.fifo_rsp_rdata !== 128'd0) begin
      bad++;
      $display("FAIL reset_rdata got=%h need=0", b0.fifo_rsp_rdata);
    end
    total++;
    if ({b1.biu_rsp_ready, b1.fifo_rsp_valid, b1.fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_ratio1 got rdy=%b vld=%b cnt=%0d need rdy=1 vld=0 cnt=0",
               b1.biu_rsp_ready, b1.fifo_rsp_valid, b1.fifo_count);
    end
    step();
  endtask

  task automatic test_full_word();
    logic [127:0] d; logic [3:0] m; logic l; logic ok;
    w0_t e;
    send0(32'h11, 1'b0);
    send0(32'h22, 1'b0);
    send0(32'h33, 1'b0);
    total++;
    if (b0.fifo_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_word_early_valid got=%b need=0", b0.fifo_rsp_valid);
    end
    exp0(128'h00000044_00000033_00000022_00000011, 4'b1111, 1'b1);
    send0(32'h44, 1'b1);
    total++;
    if (b0.fifo_rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_word_latency got valid=%b need=1 one cycle after closing beat", b0.fifo_rsp_valid);
    end
    pop0(d, m, l, ok);
    e = q0.pop_front();
    total++;
    if (!ok || d !== e.data || m !== e.mask || l !== e.last) begin
      bad++;
      $display("FAIL full_word got ok=%b d=%h m=%b l=%b need d=%h m=%b l=%b", ok, d, m, l, e.data, e.mask, e.last);
    end
  endtask

  task automatic test_partial_word();
    logic [127:0] d; logic [3:0] m; logic l; logic ok;
    w0_t e;
    exp0(128'h0000000B_0000000A, 4'b0011, 1'b1);
    send0(32'hA, 1'b0);
    send0(32'hB, 1'b1);
    pop0(d, m, l, ok);
    e = q0.pop_front();
    total++;
    if (!ok || d !== e.data || m !== e.mask || l !== e.last) begin
      bad++;
      $display("FAIL partial_word got ok=%b d=%h m=%b l=%b need d=%h m=%b l=%b", ok, d, m, l, e.data, e.mask, e.last);
    end
    exp0(128'h00000005, 4'b0001, 1'b1);
    send0(32'h5, 1'b1);
    pop0(d, m, l, ok);
    e = q0.pop_front();
    total++;
    if (!ok || d !== e.data || m !== e.mask || l !== e.last) begin
      bad++;
      $display("FAIL partial_next_lane0 got ok=%b d=%h m=%b l=%b need d=%h m=%b l=%b", ok, d, m, l, e.data, e.mask, e.last);
    end
  endtask

  task automatic test_full_backpressure();
    logic [127:0] w; logic [127:0] h; logic [3:0] hm; logic hl;
    logic [127:0] d; logic [3:0] m; logic l; logic ok;
    w0_t e;
    w = '0;
    b0.fifo_rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w[(i % 4) * 32 +: 32] = 32'h100 + 32'(i);
      if (i % 4 == 3) exp0(w, 4'b1111, (i == 7 || i == 15));
      send0(32'h100 + 32'(i), (i == 7 || i == 15));
    end
    @(negedge clk);
    total++;
    if ({b0.fifo_count, b0.fifo_afull, b0.biu_rsp_ready} !== {3'd4, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL full_status got cnt=%0d afull=%b rdy=%b need cnt=4 afull=1 rdy=0",
               b0.fifo_count, b0.fifo_afull, b0.biu_rsp_ready);
    end
    h  = b0.fifo_rsp_rdata;
    hm = b0.fifo_rsp_mask;
    hl = b0.fifo_rsp_last;
    total++;
    if (h !== q0[0].data) begin
      bad++;
      $display("FAIL full_head got=%h need=%h", h, q0[0].data);
    end
    step();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (b0.fifo_rsp_valid !== 1'b1 || b0.fifo_rsp_rdata !== h || b0.fifo_rsp_mask !== hm || b0.fifo_rsp_last !== hl) begin
        bad++;
        $display("FAIL hold_stable cycle=%0d got vld=%b d=%h need vld=1 d=%h", c, b0.fifo_rsp_valid, b0.fifo_rsp_rdata, h);
      end
      step();
    end
    b0.fifo_rsp_ready = 1'b1;
    @(negedge clk);
    d = b0.fifo_rsp_rdata; m = b0.fifo_rsp_mask; l = b0.fifo_rsp_last;
    total++;
    if (b0.biu_rsp_ready !== 1'b0) begin
      bad++;
      $display("FAIL no_bypass got rdy=%b need rdy=0 in the pop cycle", b0.biu_rsp_ready);
    end
    step();
    b0.fifo_rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (b0.biu_rsp_ready !== 1'b1 || b0.fifo_count !== 3'd3) begin
      bad++;
      $display("FAIL ready_after_pop got rdy=%b cnt=%0d need rdy=1 cnt=3", b0.biu_rsp_ready, b0.fifo_count);
    end
    step();
    e = q0.pop_front();
    total++;
    if (d !== e.data || m !== e.mask || l !== e.last) begin
      bad++;
      $display("FAIL full_pop0 got d=%h m=%b l=%b need d=%h m=%b l=%b", d, m, l, e.data, e.mask, e.last);
    end
    for (int k = 1; k < 4; k++) begin
      pop0(d, m, l, ok);
      e = q0.pop_front();
      total++;
      if (!ok || d !== e.data || m !== e.mask || l !== e.last) begin
        bad++;
        $display("FAIL full_drain%0d got ok=%b d=%h m=%b l=%b need d=%h m=%b l=%b", k, ok, d, m, l, e.data, e.mask, e.last);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d; logic [3:0] m; logic l; logic ok;
    w0_t e;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) exp0(128'h00000203_00000202_00000201_00000200, 4'b1111, 1'b0);
      if (i == 7) exp0(128'h00000207_00000206_00000205_00000204, 4'b1111, 1'b1);
      send0(32'h200 + 32'(i), (i == 7));
    end
    exp0(128'h00000077, 4'b0001, 1'b1);
    b0.biu_rsp_valid  = 1'b1;
    b0.biu_rsp_rdata  = 32'h77;
    b0.biu_rsp_last   = 1'b1;
    b0.fifo_rsp_ready = 1'b1;
    @(negedge clk);
    d = b0.fifo_rsp_rdata; m = b0.fifo_rsp_mask; l = b0.fifo_rsp_last;
    total++;
    if ({b0.biu_rsp_ready, b0.fifo_rsp_valid, b0.fifo_count} !== {1'b1, 1'b1, 3'd2}) begin
      bad++;
      $display("FAIL simul_pre got rdy=%b vld=%b cnt=%0d need rdy=1 vld=1 cnt=2", b0.biu_rsp_ready, b0.fifo_rsp_valid, b0.fifo_count);
    end
    step();
    b0.biu_rsp_valid  = 1'b0;
    b0.biu_rsp_last   = 1'b0;
    b0.fifo_rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (b0.fifo_count !== 3'd2) begin
      bad++;
      $display("FAIL simul_count got=%0d need=2", b0.fifo_count);
    end
    step();
    e = q0.pop_front();
    total++;
    if (d !== e.data || m !== e.mask || l !== e.last) begin
      bad++;
      $display("FAIL simul_pop got d=%h m=%b l=%b need d=%h m=%b l=%b", d, m, l, e.data, e.mask, e.last);
    end
    for (int k = 0; k < 2; k++) begin
      pop0(d, m, l, ok);
      e = q0.pop_front();
      total++;
      if (!ok || d !== e.data || m !== e.mask || l !== e.last) begin
        bad++;
        $display("FAIL simul_order%0d got ok=%b d=%h m=%b l=%b need d=%h m=%b l=%b", k, ok, d, m, l, e.data, e.mask, e.last);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d; logic [3:0] m; logic l; logic ok;
    w0_t e;
    for (int i = 0; i < 6; i++) send0(32'h300 + 32'(i), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({b0.fifo_count, b0.fifo_rsp_valid, b0.fifo_rsp_rdata} !== {3'd0, 1'b0, 128'd0}) begin
      bad++;
      $display("FAIL reset_mid_state got cnt=%0d vld=%b d=%h need cnt=0 vld=0 d=0", b0.fifo_count, b0.fifo_rsp_valid, b0.fifo_rsp_rdata);
    end
    step();
    q0.delete();
    exp0(128'h00000024_00000023_00000022_00000021, 4'b1111, 1'b1);
    send0(32'h21, 1'b0);
    send0(32'h22, 1'b0);
    send0(32'h23, 1'b0);
    send0(32'h24, 1'b1);
    pop0(d, m, l, ok);
    e = q0.pop_front();
    total++;
    if (!ok || d !== e.data || m !== e.mask || l !== e.last) begin
      bad++;
      $display("FAIL reset_mid_clean got ok=%b d=%h m=%b l=%b need d=%h m=%b l=%b", ok, d, m, l, e.data, e.mask, e.last);
    end
  endtask

  task automatic test_ratio1_random();
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    fork
      begin : producer
        for (int i = 0; i < 1000; i++) begin
          w1_t  e;
          logic took;
          int   n;
          e.data = {$urandom, $urandom};
          e.last = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 2)) step();
          q1.push_back(e);
          b1.biu_rsp_valid = 1'b1;
          b1.biu_rsp_rdata = e.data;
          b1.biu_rsp_last  = e.last;
          took = 1'b0;
          n    = 0;
          while (!took && n < 200) begin
            @(negedge clk);
            took = b1.biu_rsp_ready;
            step();
            n++;
          end
          b1.biu_rsp_valid = 1'b0;
          if (!took) begin
            total++;
            bad++;
            $display("FAIL ratio1_accept beat=%0d got ready=0 need ready=1 within 200 cycles", i);
          end
        end
      end
      begin : consumer
        while (got < 1000 && cyc < 20000) begin
          w1_t e;
          b1.fifo_rsp_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (b1.fifo_rsp_valid && b1.fifo_rsp_ready) begin
            total++;
            if (q1.size() == 0) begin
              bad++;
              $display("FAIL ratio1_extra got d=%h need no word", b1.fifo_rsp_rdata);
            end else begin
              e = q1.pop_front();
              if (b1.fifo_rsp_rdata !== e.data || b1.fifo_rsp_last !== e.last || b1.fifo_rsp_mask !== 1'b1) begin
                bad++;
                $display("FAIL ratio1_word%0d got d=%h l=%b m=%b need d=%h l=%b m=1",
                         got, b1.fifo_rsp_rdata, b1.fifo_rsp_last, b1.fifo_rsp_mask, e.data, e.last);
              end
            end
            got++;
          end
          step();
          cyc++;
        end
        b1.fifo_rsp_ready = 1'b0;
      end
    join
    total++;
    if (got != 1000 || q1.size() != 0) begin
      bad++;
      $display("FAIL ratio1_count got words=%0d left=%0d need words=1000 left=0", got, q1.size());
    end
  endtask

  initial begin
    rst               = 1'b1;
    b0.biu_rsp_valid  = 1'b0;
    b0.biu_rsp_rdata  = '0;
    b0.biu_rsp_last   = 1'b0;
    b0.fifo_rsp_ready = 1'b0;
    b1.biu_rsp_valid  = 1'b0;
    b1.biu_rsp_rdata  = '0;
    b1.biu_rsp_last   = 1'b0;
    b1.fifo_rsp_ready = 1'b0;
    test_reset();
    test_full_word();
    test_partial_word();
    test_full_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_ratio1_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rsp_wc.md
# fifo_rsp_wc

Parametrised response FIFO with upsizing width conversion between the BIU response channel and the processor response port. It packs RATIO = OUT_WIDTH/IN_WIDTH narrow BIU beats into one wide processor word, and closes partial words early on `biu_rsp_last`. Each word carries a per-lane valid mask and a last flag. The output is first-word-fall-through with a true valid/ready handshake, plus occupancy and almost-full status for the request-side throttle.

## Interface
- FIFO_DEPTH, 8: stored wide words; power of 2, ≥ 2
- IN_WIDTH, 32: BIU beat width
- OUT_WIDTH, 128: processor word width; integer multiple of IN_WIDTH (RATIO ≥ 1)
- AFULL_THRESH, FIFO_DEPTH-2: `fifo_afull` asserts when count ≥ this value; range 1..FIFO_DEPTH
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- biu_rsp_valid  in  1  BIU beat valid
- biu_rsp_ready  out  1  beat accepted when valid && ready
- biu_rsp_rdata  in  IN_WIDTH  beat data
- biu_rsp_last  in  1  final beat of a response; closes the current word
- fifo_rsp_valid  out  1  head word available
- fifo_rsp_ready  in  1  processor pops head when valid && ready
- fifo_rsp_rdata  out  OUT_WIDTH  head word; lane i = bits [i*IN_WIDTH +: IN_WIDTH]
- fifo_rsp_mask  out  RATIO  lane-valid mask of head word
- fifo_rsp_last  out  1  head word ends a response
- fifo_count  out  $clog2(FIFO_DEPTH)+1  stored words
- fifo_afull  out  1  count ≥ AFULL_THRESH

## Operation
- Packer: lane index `lane` (0..RATIO-1) and accumulator of RATIO-1 lanes plus mask bits.
- An accepted beat writes lane `lane`.
  - If `lane == RATIO-1` or `biu_rsp_last`: push one entry {data = beat merged with accumulator, mask, last = biu_rsp_last} at wr_ptr. Then clear `lane`, the accumulator and the mask.
  - Otherwise: store the beat in the accumulator and increment `lane`.
- Lanes not written in a closed word read as zero; their mask bits are 0. Mask bits are always contiguous from bit 0.
- RATIO = 1: every beat is a full word, with mask = 1'b1.
- `biu_rsp_ready` = !full && !rst. It does not depend on `biu_rsp_valid`. It is held low while the FIFO is full, including beats that would not close a word, so that packer state never overruns storage.
- Storage: FIFO_DEPTH entries of {data, mask, last}. Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - empty = pointers equal.
  - full = MSBs differ and the low bits are equal.
- Output: `fifo_rsp_valid` = !empty. `fifo_rsp_rdata`, `fifo_rsp_mask` and `fifo_rsp_last` are driven directly from the head entry (FWFT), and hold stable while valid && !ready.
- Pop on fifo_rsp_valid && fifo_rsp_ready; rd_ptr increments.
- A simultaneous push and pop in one cycle leaves the count unchanged. When full, a pop frees space; `biu_rsp_ready` rises the following cycle (no same-cycle bypass).
- `fifo_count` = wr_ptr − rd_ptr, in pointer width. It counts closed words only, never the partial accumulator.

## Timing
- Reset: rst high at a clock edge clears pointers, `lane`, the accumulator and the mask. A reset in the middle of a response discards stored words and any partial word.
- Output values while and after reset:
  - `fifo_rsp_valid` = 0
  - `biu_rsp_ready` = 0 while rst is high, 1 in the first cycle after
  - `fifo_count` = 0
  - `fifo_afull` = 0
  - `fifo_rsp_mask` = 0
  - `fifo_rsp_last` = 0
  - `fifo_rsp_rdata` = 0 (head entry reads zero after reset)
- Latency: the beat that closes a word at edge N makes `fifo_rsp_valid` = 1 after edge N. Minimum beat-to-word latency is 1 cycle.
- Throughput: 1 beat/cycle in; 1 word/cycle out.
- `fifo_afull` and `fifo_count` are combinational from the registered pointers and are valid in the same cycle as the pointers.

## Structure
- Package `fifo_rsp_pkg` holds the default parameter constants and a `clog2`-based pointer-width helper function. The entry struct is module-local, since it is width-parametric.
- One sub-module, `rsp_packer`, contains the lane counter, accumulator, mask and close logic. It outputs push, data, mask and last. The top level holds the storage, the pointers and the status logic.
- Elaboration-time assertions check that OUT_WIDTH % IN_WIDTH == 0, that FIFO_DEPTH is a power of 2, and that AFULL_THRESH is in range.

## Test plan
Default configuration for all cases except the last: IN=32, OUT=128, DEPTH=4, AFULL_THRESH=2.
- Full word: beats 0x11, 0x22, 0x33, 0x44 with last on the 4th → one word, rdata = 0x00000044_00000033_00000022_00000011, mask = 4'b1111, last = 1. Valid rises 1 cycle after the 4th beat.
- Partial word: beats 0xA, 0xB with last on the 2nd → rdata = 0x0…0000000B_0000000A, mask = 4'b0011, last = 1. The next beat lands in lane 0.
- Full and backpressure: fifo_rsp_ready = 0 while 16 beats are sent → count = 4, afull = 1, and `biu_rsp_ready` drops after the 16th beat. Hold head data stable for 10 cycles; then pop once → `biu_rsp_ready` = 1 on the next cycle.
- Simultaneous push and pop at count = 2 → count stays 2, and words emerge in order.
- Reset mid-response: 2 of 4 beats accepted, plus 1 stored word, then a 1-cycle rst → count = 0, valid = 0. The next 4 beats form a clean word with mask = 4'b1111.
- RATIO = 1 (IN = OUT = 64), random valid/ready for 1000 beats → the scoreboard matches exactly, and mask = 1 on every word.
